input_conditioner: RTL and testbench

- Conditions the raw DE1-SoC KEY[3:0] and SW[9:0] pins before they reach the Nios system's button and switch PIOs.
- Provides metastability synchronisers, tick-based debouncing and one-cycle edge pulses.
- key_clean drives button_pio_external_connection_export[3:0]; sw_clean drives sw_pio_external_connection_export[9:0].
- Pulse outputs are spare for hardware consumers such as IRQ or capture logic.

---
 rtl/input_conditioner_if.sv | 22 ++
 rtl/input_conditioner.sv | 100 ++++++++++
 tb/tb_input_conditioner.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pin inputs and conditioned outputs of the DE1-SoC key/switch conditioner
interface input_conditioner_if #(
  parameter int N_KEY = 4,
  parameter int N_SW = 10
);
  logic [N_KEY-1:0] key_raw;
  logic [N_SW-1:0] sw_raw;
  logic [N_KEY-1:0] key_clean;
  logic [N_SW-1:0] sw_clean;
  logic [N_KEY-1:0] key_press_pulse;
  logic [N_KEY-1:0] key_release_pulse;
  logic [N_SW-1:0] sw_change_pulse;
  logic ready;
  modport master (
    output key_raw, sw_raw,
    input key_clean, sw_clean, key_press_pulse, key_release_pulse, sw_change_pulse, ready
  );
  modport slave (
    input key_raw, sw_raw,
    output key_clean, sw_clean, key_press_pulse, key_release_pulse, sw_change_pulse, ready
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and edge-detect DE1-SoC KEY/SW pins
module input_conditioner #(
  parameter int N_KEY = 4,
  parameter int N_SW = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 20
) (
  input logic clk,
  input logic reset_n,
  input_conditioner_if.slave io
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [IW-1:0] init_cnt;
  logic [PW-1:0] pre;
  logic tick;
  logic rdy;
  logic [N_KEY-1:0] key_ff [SYNC_STAGES];
  logic [N_SW-1:0] sw_ff [SYNC_STAGES];
  logic [N_KEY-1:0] key_sync, key_clean, key_press, key_rel;
  logic [N_SW-1:0] sw_sync, sw_clean, sw_chg;
  logic [CW-1:0] key_cnt [N_KEY];
  logic [CW-1:0] sw_cnt [N_SW];
  assign key_sync = key_ff[SYNC_STAGES-1];
  assign sw_sync = sw_ff[SYNC_STAGES-1];
  assign tick = pre == PW'(TICK_DIV - 1);
  assign io.key_clean = key_clean;
  assign io.sw_clean = sw_clean;
  assign io.key_press_pulse = key_press;
  assign io.key_release_pulse = key_rel;
  assign io.sw_change_pulse = sw_chg;
  assign io.ready = rdy;
  // metastability synchroniser chains; keys idle high, switches idle low
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        key_ff[i] <= '1;
        sw_ff[i] <= '0;
      end
    end else begin
      key_ff[0] <= io.key_raw;
      sw_ff[0] <= io.sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        key_ff[i] <= key_ff[i-1];
        sw_ff[i] <= sw_ff[i-1];
      end
    end
  // INIT loads the synchronised levels once, then RUN debounces every channel on each tick
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INIT;
      init_cnt <= '0;
      pre <= '0;
      rdy <= 1'b0;
      key_clean <= '1;
      sw_clean <= '0;
      key_press <= '0;
      key_rel <= '0;
      sw_chg <= '0;
      for (int i = 0; i < N_KEY; i++) key_cnt[i] <= '0;
      for (int i = 0; i < N_SW; i++) sw_cnt[i] <= '0;
    end else begin
      key_press <= '0;
      key_rel <= '0;
      sw_chg <= '0;
      if (state == INIT) begin
        init_cnt <= init_cnt + IW'(1);
        if (init_cnt == IW'(SYNC_STAGES)) begin
          key_clean <= key_sync;
          sw_clean <= sw_sync;
          rdy <= 1'b1;
          state <= RUN;
        end
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) begin
          for (int i = 0; i < N_KEY; i++)
            if (key_sync[i] == key_clean[i]) key_cnt[i] <= '0;
            else if (key_cnt[i] == LAST) begin
              key_clean[i] <= key_sync[i];
              key_cnt[i] <= '0;
              key_press[i] <= key_clean[i];
              key_rel[i] <= ~key_clean[i];
            end else key_cnt[i] <= key_cnt[i] + CW'(1);
          for (int i = 0; i < N_SW; i++)
            if (sw_sync[i] == sw_clean[i]) sw_cnt[i] <= '0;
            else if (sw_cnt[i] == LAST) begin
              sw_clean[i] <= sw_sync[i];
              sw_cnt[i] <= '0;
              sw_chg[i] <= 1'b1;
            end else sw_cnt[i] <= sw_cnt[i] + CW'(1);
        end
      end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table, directed and randomized checks against a cycle-level reference model
module tb_input_conditioner;
  localparam int NK = 4, NS = 10, SY = 2, TD = 4, ST = 3;
  logic clk = 0, reset_n = 0;
  int checks = 0, errors = 0;
  input_conditioner_if #(.N_KEY(NK), .N_SW(NS)) bus ();
  input_conditioner #(.N_KEY(NK), .N_SW(NS), .SYNC_STAGES(SY), .TICK_DIV(TD), .STABLE_TICKS(ST))
    dut (.clk(clk), .reset_n(reset_n), .io(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // reference model: delay line for synchronisers, edge count for INIT/ticks, run length of mismatching tick samples
  logic [13:0] pipe [$];
  logic [13:0] s;
  logic [3:0] mk, mp, mr;
  logic [9:0] ms, mc;
  logic mready, cur;
  int e;
  int run [14];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pipe = {};
      for (int i = 0; i < SY; i++) pipe.push_back({4'hF, 10'h000});
      mk = 4'hF; ms = 0; mp = 0; mr = 0; mc = 0; mready = 0; e = 0;
      for (int b = 0; b < 14; b++) run[b] = 0;
    end else begin
      s = pipe[0];
      mp = 0; mr = 0; mc = 0;
      e++;
      if (e == SY + 1) begin
        {mk, ms} = s;
        mready = 1;
      end else if (e > SY + 1 && (e - SY - 1) % TD == 0) begin
        for (int b = 0; b < 14; b++) begin
          cur = b < 10 ? ms[b] : mk[b-10];
          if (s[b] != cur) begin
            run[b]++;
            if (run[b] == ST) begin
              run[b] = 0;
              if (b < 10) begin ms[b] = s[b]; mc[b] = 1; end
              else begin mk[b-10] = s[b]; mp[b-10] = cur; mr[b-10] = ~cur; end
            end
          end else run[b] = 0;
        end
      end
      void'(pipe.pop_front());
      pipe.push_back({bus.key_raw, bus.sw_raw});
    end
  // per-cycle comparison against the model, plus pulse tallies for the directed sequences
  int press_cnt [4], rel_cnt [4], chg_cnt [10], all_chg;
  always @(negedge clk) begin
    if (errors < 40) begin
      chk("model_ready", bus.ready, mready);
      chk("model_key_clean", bus.key_clean, mk);
      chk("model_sw_clean", bus.sw_clean, ms);
      chk("model_press", bus.key_press_pulse, mp);
      chk("model_release", bus.key_release_pulse, mr);
      chk("model_change", bus.sw_change_pulse, mc);
    end
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] += bus.key_press_pulse[i];
      rel_cnt[i] += bus.key_release_pulse[i];
    end
    for (int i = 0; i < 10; i++) chg_cnt[i] += bus.sw_change_pulse[i];
    if (bus.sw_change_pulse == 10'h3FF) all_chg++;
  end
  task automatic clr();
    for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    for (int i = 0; i < 10; i++) chg_cnt[i] = 0;
    all_chg = 0;
  endtask
  task automatic drive(input logic [3:0] k, input logic [9:0] sw, input int n);
    bus.key_raw = k;
    bus.sw_raw = sw;
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int sum4(input int a [4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction
  typedef struct {logic [3:0] key; logic [9:0] sw; int hold; logic [3:0] exp_key; logic [9:0] exp_sw;} vec_t;
  vec_t tbl [10];
  logic [3:0] rk;
  logic [9:0] rs;
  initial begin
    tbl[0] = '{4'hF, 10'h2A5, 20, 4'hF, 10'h2A5};
    tbl[1] = '{4'hE, 10'h2A5, 20, 4'hE, 10'h2A5};
    tbl[2] = '{4'hF, 10'h2A5, 20, 4'hF, 10'h2A5};
    tbl[3] = '{4'hD, 10'h2A5, 5, 4'hF, 10'h2A5};
    tbl[4] = '{4'hF, 10'h2A5, 20, 4'hF, 10'h2A5};
    tbl[5] = '{4'hF, 10'h000, 20, 4'hF, 10'h000};
    tbl[6] = '{4'hF, 10'h3FF, 20, 4'hF, 10'h3FF};
    tbl[7] = '{4'h0, 10'h3FF, 4, 4'hF, 10'h3FF};
    tbl[8] = '{4'h0, 10'h155, 20, 4'h0, 10'h155};
    tbl[9] = '{4'hF, 10'h155, 20, 4'hF, 10'h155};
    clr();
    bus.key_raw = 4'hF;
    bus.sw_raw = 10'h2A5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", bus.ready, 0);
    chk("reset_key_clean", bus.key_clean, 4'hF);
    chk("reset_sw_clean", bus.sw_clean, 0);
    reset_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_before_3rd_edge", bus.ready, 0);
    @(posedge clk);
    #1;
    chk("ready_at_3rd_edge", bus.ready, 1);
    chk("load_sw_clean", bus.sw_clean, 10'h2A5);
    chk("load_key_clean", bus.key_clean, 4'hF);
    chk("load_no_pulses", sum4(press_cnt) + sum4(rel_cnt), 0);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].key, tbl[i].sw, tbl[i].hold);
      chk($sformatf("tbl%0d_key", i), bus.key_clean, tbl[i].exp_key);
      chk($sformatf("tbl%0d_sw", i), bus.sw_clean, tbl[i].exp_sw);
    end
    clr();
    drive(4'hE, 10'h000, 20);
    chk("press_key_clean", bus.key_clean, 4'hE);
    chk("press_pulse_once", press_cnt[0], 1);
    chk("press_no_release", sum4(rel_cnt), 0);
    drive(4'hF, 10'h000, 20);
    chk("release_pulse_once", rel_cnt[0], 1);
    chk("release_press_total", sum4(press_cnt), 1);
    clr();
    drive(4'hD, 10'h000, 2 * TD);
    drive(4'hF, 10'h000, 20);
    chk("glitch_key_clean", bus.key_clean, 4'hF);
    chk("glitch_no_pulse", sum4(press_cnt) + sum4(rel_cnt), 0);
    clr();
    rs = 0;
    for (int i = 0; i < 14; i++) begin
      rs[3] = ~rs[3];
      drive(4'hF, rs, 3);
    end
    drive(4'hF, 10'h008, 20);
    chk("bounce_one_pulse", chg_cnt[3], 1);
    chk("bounce_sw_clean", bus.sw_clean, 10'h008);
    drive(4'hF, 10'h000, 20);
    clr();
    drive(4'hF, 10'h3FF, 20);
    chk("simul_sw_clean", bus.sw_clean, 10'h3FF);
    chk("simul_joint_pulse", all_chg, 1);
    chk("simul_bit9_once", chg_cnt[9], 1);
    chk("simul_bit0_once", chg_cnt[0], 1);
    drive(4'hF, 10'h000, 20);
    clr();
    drive(4'hB, 10'h000, 2 + 2 * TD);
    chk("midcount_key_clean", bus.key_clean, 4'hF);
    #3 reset_n = 0;
    #1;
    chk("async_ready", bus.ready, 0);
    chk("async_key_clean", bus.key_clean, 4'hF);
    chk("async_sw_clean", bus.sw_clean, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reload_ready", bus.ready, 1);
    chk("reload_key_clean", bus.key_clean, 4'hB);
    drive(4'hB, 10'h000, 10);
    chk("reload_no_press", sum4(press_cnt), 0);
    for (int i = 0; i < 150; i++) begin
      rk = bus.key_raw;
      rs = bus.sw_raw;
      if ($urandom_range(0, 1)) begin
        rk[$urandom_range(0, 3)] ^= 1'b1;
        rs[$urandom_range(0, 9)] ^= 1'b1;
      end else begin
        rk = 4'($urandom);
        rs = 10'($urandom);
      end
      drive(rk, rs, $urandom_range(1, 25));
    end
    drive(bus.key_raw, bus.sw_raw, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
